// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial wide adder.
// Contents: the FSM state encoding and the width of one datapath slice.
package nibble_serial_adder_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Request/result bundle between a requester and the nibble-serial adder.
// master: drives start, a, b, c_in; observes busy, done, sum, c_out.
// slave : the adder side (mirror of master).
interface nibble_serial_adder_if #(
  parameter int unsigned NIBBLES = 4
);
  import nibble_serial_adder_pkg::*;

  localparam int unsigned W = NIBBLE_W * NIBBLES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;

  modport master (
    output start, a, b, c_in,
    input  busy, done, sum, c_out
  );

  modport slave (
    input  start, a, b, c_in,
    output busy, done, sum, c_out
  );

endinterface

// File: rtl/four_bits_full_adder.sv
// Existing 4-bit ripple adder slice, used as-is by the serial adder.
// Ports: a, b (4-bit operands), c_in (carry in) -> sum (4-bit), c_out.
module four_bits_full_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);

  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + 5'(c_in);

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that feeds one 4-bit adder slice a nibble per clock, LSB first,
// with the carry held in a register between nibbles.
// Ports: clk, rst_n (synchronous, active low), bus (slave side of
// nibble_serial_adder_if: start/a/b/c_in in, busy/done/sum/c_out out).
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nibble_serial_adder_if.slave bus
);

  localparam int unsigned W     = NIBBLE_W * NIBBLES;
  localparam int unsigned IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t state;
  state_t next_state;

  logic             busy_q;
  logic             done_q;
  logic             busy_d;
  logic             done_d;
  logic             accept_c;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     sum_q;
  logic             carry_q;
  logic             c_out_q;
  logic [IDX_W-1:0] idx_q;

  logic [NIBBLE_W-1:0] add_a_c;
  logic [NIBBLE_W-1:0] add_b_c;
  logic [NIBBLE_W-1:0] add_sum_c;
  logic                add_co_c;

  // State register plus registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= next_state;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // Next state; a new request is taken in IDLE or in the DONE cycle.
  always_comb begin
    next_state = state;
    accept_c   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept_c   = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        if (idx_q == LAST_IDX) next_state = DONE;
      end
      DONE: begin
        if (bus.start) begin
          accept_c   = 1'b1;
          next_state = RUN;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    busy_d = (next_state == RUN);
    done_d = (next_state == DONE);
  end

  // Select the current nibble of each operand for the slice.
  always_comb begin
    add_a_c = '0;
    add_b_c = '0;
    for (int i = 0; i < int'(NIBBLES); i++) begin
      if (idx_q == IDX_W'(i)) begin
        add_a_c = a_q[i*NIBBLE_W +: NIBBLE_W];
        add_b_c = b_q[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  four_bits_full_adder u_slice (
    .a     (add_a_c),
    .b     (add_b_c),
    .c_in  (carry_q),
    .sum   (add_sum_c),
    .c_out (add_co_c)
  );

  // Operand capture, carry chaining and result assembly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      idx_q   <= '0;
    end else if (accept_c) begin
      a_q     <= bus.a;
      b_q     <= bus.b;
      carry_q <= bus.c_in;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      idx_q   <= '0;
    end else if (state == RUN) begin
      for (int i = 0; i < int'(NIBBLES); i++) begin
        if (idx_q == IDX_W'(i)) sum_q[i*NIBBLE_W +: NIBBLE_W] <= add_sum_c;
      end
      carry_q <= add_co_c;
      if (idx_q == LAST_IDX) begin
        c_out_q <= add_co_c;
        idx_q   <= '0;
      end else begin
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: a 16-bit instance for directed
// vectors and handshake/reset cases, and an 8-bit instance for random adds.
module tb_nibble_serial_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [16:0] q4[$];
  logic [8:0]  q2[$];

  nibble_serial_adder_if #(.NIBBLES(4)) if4 ();
  nibble_serial_adder_if #(.NIBBLES(2)) if2 ();

  nibble_serial_adder #(.NIBBLES(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4)
  );

  nibble_serial_adder #(.NIBBLES(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor for the 16-bit instance: every done pops one expected result.
  always @(negedge clk) begin
    if (if4.done === 1'b1) begin
      if (q4.size() == 0) begin
        check("done4_unexpected", 32'(if4.done), 32'(0));
      end else begin
        logic [16:0] e;
        e = q4.pop_front();
        check("result4", 32'({if4.c_out, if4.sum}), 32'(e));
      end
    end
  end

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    if (if2.done === 1'b1) begin
      if (q2.size() == 0) begin
        check("done2_unexpected", 32'(if2.done), 32'(0));
      end else begin
        logic [8:0] e;
        e = q2.pop_front();
        check("result2", 32'({if2.c_out, if2.sum}), 32'(e));
      end
    end
  end

  // One add on the 16-bit instance with busy/done timing checks.
  task automatic do_add4(input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic [16:0] exp);
    @(negedge clk);
    if4.start = 1'b1;
    if4.a     = a;
    if4.b     = b;
    if4.c_in  = ci;
    q4.push_back(exp);
    @(negedge clk);
    if4.start = 1'b0;
    if4.a     = 16'($urandom);
    if4.b     = 16'($urandom);
    if4.c_in  = 1'($urandom);
    for (int i = 0; i < 4; i++) begin
      check("busy_run", 32'(if4.busy), 32'(1));
      check("done_run", 32'(if4.done), 32'(0));
      @(negedge clk);
    end
    check("done_pulse", 32'(if4.done), 32'(1));
    check("busy_in_done", 32'(if4.busy), 32'(0));
  endtask

  // One add on the 8-bit instance with a bounded wait for done.
  task automatic do_add2(input logic [7:0] a, input logic [7:0] b, input logic ci);
    int t;
    @(negedge clk);
    if2.start = 1'b1;
    if2.a     = a;
    if2.b     = b;
    if2.c_in  = ci;
    q2.push_back(9'(a) + 9'(b) + 9'(ci));
    @(negedge clk);
    if2.start = 1'b0;
    if2.a     = 8'($urandom);
    if2.b     = 8'($urandom);
    t = 0;
    while (if2.done !== 1'b1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("done2_seen", 32'(if2.done), 32'(1));
    check("latency2", 32'(t), 32'(2));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    // Reset with start asserted: reset must win.
    rst_n     = 1'b0;
    if4.start = 1'b1;
    if4.a     = 16'h1234;
    if4.b     = 16'h1111;
    if4.c_in  = 1'b1;
    if2.start = 1'b1;
    if2.a     = 8'h12;
    if2.b     = 8'h34;
    if2.c_in  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(if4.busy), 32'(0));
    check("rst_done", 32'(if4.done), 32'(0));
    check("rst_sum", 32'(if4.sum), 32'(0));
    check("rst_cout", 32'(if4.c_out), 32'(0));
    check("rst_busy2", 32'(if2.busy), 32'(0));
    if4.start = 1'b0;
    if2.start = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(if4.busy), 32'(0));

    // Directed vectors.
    do_add4(16'h0000, 16'h0000, 1'b0, {1'b0, 16'h0000});
    do_add4(16'hFFFF, 16'h0001, 1'b0, {1'b1, 16'h0000});
    do_add4(16'hFFFF, 16'h0000, 1'b1, {1'b1, 16'h0000});
    do_add4(16'h1234, 16'h4321, 1'b1, {1'b0, 16'h5556});
    do_add4(16'h8000, 16'h8000, 1'b0, {1'b1, 16'h0000});
    do_add4(16'h0F0F, 16'h00F1, 1'b0, {1'b0, 16'h1000});

    // Start held for six edges; second request taken in the DONE cycle.
    @(negedge clk);
    if4.start = 1'b1;
    if4.a     = 16'h0001;
    if4.b     = 16'h0001;
    if4.c_in  = 1'b0;
    q4.push_back({1'b0, 16'h0002});
    @(negedge clk);
    if4.a = 16'h00FF;
    q4.push_back({1'b0, 16'h0100});
    repeat (4) @(negedge clk);
    check("hs_done1", 32'(if4.done), 32'(1));
    @(negedge clk);
    if4.start = 1'b0;
    check("hs_rerun_busy", 32'(if4.busy), 32'(1));
    t = 0;
    while (if4.done !== 1'b1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("hs_done2", 32'(if4.done), 32'(1));
    check("hs_latency", 32'(t), 32'(4));
    @(negedge clk);
    check("hs_single_done", 32'(if4.done), 32'(0));

    // Reset during the second RUN cycle aborts the add.
    @(negedge clk);
    if4.start = 1'b1;
    if4.a     = 16'hFFFF;
    if4.b     = 16'hFFFF;
    if4.c_in  = 1'b0;
    @(negedge clk);
    if4.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(if4.busy), 32'(0));
    check("abort_done", 32'(if4.done), 32'(0));
    check("abort_sum", 32'(if4.sum), 32'(0));
    check("abort_cout", 32'(if4.c_out), 32'(0));
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    do_add4(16'hFFFF, 16'hFFFF, 1'b0, {1'b1, 16'hFFFE});

    // Low-nibble sweep.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          do_add4(16'(a), 16'(b), 1'(c), 17'(a) + 17'(b) + 17'(c));
        end
      end
    end

    // Narrow instance: hand-checked edges then random operands.
    do_add2(8'hFF, 8'h01, 1'b0);
    do_add2(8'h7F, 8'h80, 1'b1);
    for (int i = 0; i < 200; i++) begin
      do_add2(8'($urandom), 8'($urandom), 1'($urandom));
    end

    repeat (4) @(negedge clk);
    check("q4_drained", 32'(q4.size()), 32'(0));
    check("q2_drained", 32'(q2.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle wide adder that streams two 4*NIBBLES-bit operands through one existing four_bits_full_adder, one nibble per clock, LSB nibble first.
- Carry is registered between nibbles.
- Sits directly upstream of four_bits_full_adder and drives its a/b/c_in; collects its sum/c_out into a result register.
- Gives wide additions at the cost of one small adder plus a start/done handshake.

Parameters:
- NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES (default 16). Legal range 2..8.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; sampled only when not busy
- a  input  W  operand A; captured on accepted start
- b  input  W  operand B; captured on accepted start
- c_in  input  1  carry-in; captured on accepted start
- busy  output  1  high while nibbles are being processed
- done  output  1  one-cycle pulse; sum/c_out valid
- sum  output  W  result, held until next accepted start
- c_out  output  1  final carry, held with sum

Behaviour:
- Reset: one clock; reset is synchronous and active-low. Sampled at a rising clk edge with rst_n=0:
  - state=IDLE, busy=0, done=0, sum=0, c_out=0.
  - Internal nibble index, carry register and operand registers are cleared to 0.
  - Reset wins over start in the same edge.
  - Reset mid-operation aborts the add; no done is produced.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 at an edge -> latch a, b, c_in; carry_reg=c_in; idx=0; sum cleared to 0; -> RUN.
  - RUN: each edge:
    - sum[4*idx+3:4*idx] <= adder sum; carry_reg <= adder c_out; idx++.
    - Adder inputs are a_reg/b_reg nibble idx and carry_reg, combinational.
    - When idx==NIBBLES-1 at the edge: c_out <= adder c_out; -> DONE.
  - DONE: lasts exactly one cycle, done=1. Next edge -> IDLE, or -> RUN if start=1 (back-to-back accept, operands latched as in IDLE).
- busy=1 exactly in RUN; done=1 exactly in DONE; both registered outputs.
- Latency: start accepted at edge k -> RUN for edges k+1..k+NIBBLES -> done high in the cycle after edge k+NIBBLES. Throughput is one add per NIBBLES+1 cycles.
- start while busy is ignored; operand registers are not disturbed.
- Input changes on a/b/c_in after acceptance have no effect.
- Arithmetic: {c_out,sum} = a + b + c_in, modulo 2^(W+1). No overflow flag; c_out is the unsigned carry.
- Carry propagates only through carry_reg, never combinationally across nibbles.
- sum/c_out are undefined to the consumer until done. In practice sum shows partial nibbles during RUN; the consumer qualifies with done.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2), NIBBLE_W=4.
- Sub-module: instantiate the existing four_bits_full_adder unchanged as the single datapath slice. No new sub-module.
- The index counter is $clog2(NIBBLES) bits, sized for NIBBLES-1.

Test Plan:
- Zero add: a=16'h0000, b=16'h0000, c_in=0, start pulse -> busy for 4 cycles; done pulse on 5th cycle after start edge; sum=16'h0000, c_out=0.
- Full ripple: a=16'hFFFF, b=16'h0001, c_in=0 -> sum=16'h0000, c_out=1.
  - Also a=16'hFFFF, b=16'h0000, c_in=1 -> sum=16'h0000, c_out=1.
- Mixed: a=16'h1234, b=16'h4321, c_in=1 -> sum=16'h5556, c_out=0.
  - Also a=16'h8000, b=16'h8000 -> sum=16'h0000, c_out=1.
- Handshake: start=1 held for 6 cycles with a=16'h0001, b=16'h0001, changing a to 16'h00FF after acceptance:
  - First result is sum=16'h0002.
  - Second start is accepted in the DONE cycle, giving done again 5 cycles later with the new operands.
  - Exactly one done per accepted start.
- Reset mid-op: start a=16'hFFFF, b=16'hFFFF, assert rst_n=0 on 2nd RUN cycle -> next cycle busy=0, done=0, sum=0, c_out=0; no done follows.
  - A fresh start afterwards gives correct sum=16'hFFFE, c_out=1.
- Sweep: nested loops over a,b in 0..15 (upper nibbles 0) with c_in 0/1, one add each, compared against a+b+c_in.
  - Repeat with NIBBLES=2 and random 8-bit operands, 200 vectors, zero mismatches.
